// File: rtl/pipe_stage_queue.sv
// rtl/pipe_stage_queue.sv - DEPTH-entry valid/ready inter-stage queue with single-cycle flush
module pipe_stage_queue #(
  parameter int DATA_W = 64,
  parameter int PID_W  = 2,
  parameter int DEPTH  = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PID_W-1:0]  pID_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [PID_W-1:0]  pID_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PID_W + DATA_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    push      = valid_i && ready_o && !flush_i;
    pop       = valid_o && ready_i && !flush_i;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  // ready_o/valid_o are registered from the next count so ready_i never reaches ready_o
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {pID_i, data_i};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      ready_o <= (count_nxt != CNT_W'(DEPTH));
      valid_o <= (count_nxt != '0);
      if (valid_i && !ready_o) overflow_o <= 1'b1;
    end
  end

  assign {pID_o, data_o} = mem[rd_ptr];
  assign count_o         = count;

endmodule

// File: tb/tb_pipe_stage_queue.sv
// tb/tb_pipe_stage_queue.sv - directed self-checking bench for pipe_stage_queue (DEPTH 2 and 4)
module tb_pipe_stage_queue;

  logic clk;
  logic reset;

  logic        f2, vi2, ri2, ro2, vo2, of2;
  logic [63:0] d2, do2;
  logic [1:0]  p2, po2;
  logic [1:0]  c2;

  logic        f4, vi4, ri4, ro4, vo4, of4;
  logic [63:0] d4, do4;
  logic [1:0]  p4, po4;
  logic [2:0]  c4;

  int total = 0;
  int bad   = 0;
  logic dead_seen = 1'b0;

  pipe_stage_queue #(.DATA_W(64), .PID_W(2), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush_i(f2), .valid_i(vi2), .ready_o(ro2),
    .data_i(d2), .pID_i(p2), .valid_o(vo2), .ready_i(ri2), .data_o(do2),
    .pID_o(po2), .count_o(c2), .overflow_o(of2)
  );

  pipe_stage_queue #(.DATA_W(64), .PID_W(2), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush_i(f4), .valid_i(vi4), .ready_o(ro4),
    .data_i(d4), .pID_i(p4), .valid_o(vo4), .ready_i(ri4), .data_o(do4),
    .pID_o(po4), .count_o(c4), .overflow_o(of4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (vo4 && do4 == 64'hDEAD) dead_seen <= 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    f2 = 0; vi2 = 0; ri2 = 0; d2 = '0; p2 = '0;
    f4 = 0; vi4 = 0; ri4 = 0; d4 = '0; p4 = '0;
    step(); step();
    reset = 1'b0;

    // reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle2 {ready,valid,count,ovf}", {59'd0, ro2, vo2, c2, of2}, 64'b10000);
      chk("idle4 {ready,valid,count,ovf}", {58'd0, ro4, vo4, c4, of4}, 64'b100000);
    end

    // push A, B then attempt C while full
    vi2 = 1; d2 = 64'h1111; p2 = 2'd1; ri2 = 0;
    step();
    chk("A count", c2, 1);
    chk("A valid", vo2, 1);
    chk("A data", do2, 64'h1111);
    d2 = 64'h2222; p2 = 2'd2;
    step();
    chk("B count", c2, 2);
    chk("B ready", ro2, 0);
    chk("B ovf", of2, 0);
    d2 = 64'h3333; p2 = 2'd3;
    step();
    chk("C ovf", of2, 1);
    chk("C count", c2, 2);
    vi2 = 0; ri2 = 1;
    chk("head A data", do2, 64'h1111);
    chk("head A pid", po2, 1);
    chk("full pop-cycle ready", ro2, 0);
    step();
    chk("pop A count", c2, 1);
    chk("head B data", do2, 64'h2222);
    chk("head B pid", po2, 2);
    chk("ready after pop", ro2, 1);
    step();
    chk("drain count", c2, 0);
    chk("drain valid", vo2, 0);
    chk("drain ovf sticky", of2, 1);
    ri2 = 0;

    // fill to full again, then reset mid-traffic
    vi2 = 1; d2 = 64'h7; p2 = 2'd0;
    step(); step();
    vi2 = 0;
    chk("refill count", c2, 2);
    chk("refill ready", ro2, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst {ready,valid,count,ovf}", {59'd0, ro2, vo2, c2, of2}, 64'b10000);
    chk("rst data", do2, 0);
    chk("rst pid", po2, 0);
    vi2 = 1; d2 = 64'h5; p2 = 2'd3;
    step();
    vi2 = 0;
    chk("post-rst valid", vo2, 1);
    chk("post-rst data", do2, 64'h5);
    chk("post-rst pid", po2, 3);
    chk("post-rst count", c2, 1);

    // DEPTH=4 streaming 0..7 with continuous ready
    vi4 = 1; ri4 = 1;
    for (int k = 0; k < 8; k++) begin
      d4 = 64'(k); p4 = 2'(k);
      step();
      chk($sformatf("stream data %0d", k), do4, 64'(k));
      chk($sformatf("stream pid %0d", k), po4, 64'(k % 4));
      chk($sformatf("stream count %0d", k), c4, 1);
    end
    vi4 = 0;
    step();
    chk("stream end count", c4, 0);
    chk("stream end valid", vo4, 0);
    ri4 = 0;

    // fill 3 of 4 then flush with an incoming DEAD beat
    vi4 = 1;
    d4 = 64'hA; step();
    d4 = 64'hB; step();
    d4 = 64'hC; step();
    chk("pre-flush count", c4, 3);
    f4 = 1; d4 = 64'hDEAD; ri4 = 1;
    step();
    f4 = 0; vi4 = 0; ri4 = 0;
    chk("flush count", c4, 0);
    chk("flush valid", vo4, 0);
    chk("flush ready", ro4, 1);
    vi4 = 1; d4 = 64'h11; p4 = 2'd2;
    step();
    vi4 = 0;
    chk("post-flush data", do4, 64'h11);
    chk("post-flush pid", po4, 2);
    chk("post-flush count", c4, 1);
    ri4 = 1;
    step(); step();
    ri4 = 0;
    chk("DEAD never output", dead_seen, 0);
    chk("dut4 ovf clear", of4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
